// File: rtl/lsu_pkg.sv
// Shared types and widths for the load/store unit and its address generator.
package lsu_pkg;
  localparam int DADDR_W = 16;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STORE,
    WB
  } lsu_state_t;
endpackage

// File: rtl/lsu_addr_gen.sv
// Effective-address adder: base plus extended offset, with wrap detection
// for both carry (positive offset) and borrow (negative offset).
module lsu_addr_gen
  import lsu_pkg::*;
#(
  parameter int OFFSET_SIGNED = 1
) (
  input  logic [DADDR_W-1:0] base,
  input  logic [DATA_W-1:0]  offset,
  output logic [DADDR_W-1:0] ea,
  output logic               wrap
);

  logic               neg_off;
  logic [DADDR_W-1:0] ext_off;
  logic [DADDR_W:0]   sum;

  // A negative offset is added as its two's complement, so a missing carry means a borrow
  always_comb begin
    neg_off = (OFFSET_SIGNED != 0) && offset[DATA_W-1];
    ext_off = neg_off ? {{(DADDR_W-DATA_W){1'b1}}, offset}
                      : {{(DADDR_W-DATA_W){1'b0}}, offset};
    sum     = {1'b0, base} + {1'b0, ext_off};
    ea      = sum[DADDR_W-1:0];
    wrap    = neg_off ? ~sum[DADDR_W] : sum[DADDR_W];
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one load or store in flight, drives the data memory ports
// and returns load results to writeback through a valid/ready handshake.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int REG_AW        = 3,
  parameter int OFFSET_SIGNED = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_is_store,
  input  logic [DADDR_W-1:0] req_base,
  input  logic [DATA_W-1:0]  req_offset,
  input  logic [DATA_W-1:0]  req_wdata,
  input  logic [REG_AW-1:0]  req_rd,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [REG_AW-1:0]  wb_rd,
  output logic [DATA_W-1:0]  wb_data,
  output logic               addr_wrap,
  output logic [DADDR_W-1:0] data_rd_addr,
  output logic [DADDR_W-1:0] data_wr_addr,
  output logic [DATA_W-1:0]  datamem_wr_data,
  output logic               store_to_mem,
  input  logic [DATA_W-1:0]  dmem_dout
);

  lsu_state_t         state, next_state;
  logic [DADDR_W-1:0] ea;
  logic               wrap;
  logic               accept;
  logic [REG_AW-1:0]  pend_rd;

  lsu_addr_gen #(.OFFSET_SIGNED(OFFSET_SIGNED)) u_addr_gen (
    .base   (req_base),
    .offset (req_offset),
    .ea     (ea),
    .wrap   (wrap)
  );

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = req_is_store ? STORE : LOAD;
      LOAD:    next_state = WB;
      STORE:   next_state = IDLE;
      WB:      if (wb_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Destination register is latched at acceptance since execute may move on afterwards
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_wrap       <= 1'b0;
      data_rd_addr    <= '0;
      data_wr_addr    <= '0;
      datamem_wr_data <= '0;
      store_to_mem    <= 1'b0;
      pend_rd         <= '0;
      wb_valid        <= 1'b0;
      wb_data         <= '0;
      wb_rd           <= '0;
    end else begin
      if (accept) begin
        addr_wrap <= wrap;
        if (req_is_store) begin
          data_wr_addr    <= ea;
          datamem_wr_data <= req_wdata;
          store_to_mem    <= 1'b1;
        end else begin
          data_rd_addr <= ea;
          pend_rd      <= req_rd;
        end
      end
      if (state == STORE) store_to_mem <= 1'b0;
      if (state == LOAD) begin
        wb_valid <= 1'b1;
        wb_data  <= dmem_dout;
        wb_rd    <= pend_rd;
      end
      if (state == WB && wb_ready) wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte memory model, hand-computed vectors,
// plus a second instance built with an unsigned offset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_store;
  logic [15:0] req_base;
  logic [7:0]  req_offset, req_wdata;
  logic [2:0]  req_rd;
  logic        wb_valid, wb_ready;
  logic [2:0]  wb_rd;
  logic [7:0]  wb_data;
  logic        addr_wrap;
  logic [15:0] data_rd_addr, data_wr_addr;
  logic [7:0]  datamem_wr_data;
  logic        store_to_mem;
  logic [7:0]  dmem_dout;

  logic        u2_req_valid, u2_req_ready;
  logic [15:0] u2_req_base;
  logic [7:0]  u2_req_offset;
  logic        u2_wb_valid;
  logic [2:0]  u2_wb_rd;
  logic [7:0]  u2_wb_data;
  logic        u2_addr_wrap;
  logic [15:0] u2_data_rd_addr, u2_data_wr_addr;
  logic [7:0]  u2_datamem_wr_data;
  logic        u2_store_to_mem;

  logic [7:0]  mem     [0:65535];
  bit          written [0:65535];
  int          strobe_count = 0;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_rd_addr;

  always #5 clk = ~clk;

  load_store_unit #(.REG_AW(3), .OFFSET_SIGNED(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata), .req_rd(req_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .addr_wrap(addr_wrap), .data_rd_addr(data_rd_addr), .data_wr_addr(data_wr_addr),
    .datamem_wr_data(datamem_wr_data), .store_to_mem(store_to_mem), .dmem_dout(dmem_dout)
  );

  load_store_unit #(.REG_AW(3), .OFFSET_SIGNED(0)) dut_unsigned (
    .clk(clk), .reset(reset),
    .req_valid(u2_req_valid), .req_ready(u2_req_ready), .req_is_store(1'b0),
    .req_base(u2_req_base), .req_offset(u2_req_offset), .req_wdata(8'h00), .req_rd(3'd0),
    .wb_valid(u2_wb_valid), .wb_ready(1'b1), .wb_rd(u2_wb_rd), .wb_data(u2_wb_data),
    .addr_wrap(u2_addr_wrap), .data_rd_addr(u2_data_rd_addr), .data_wr_addr(u2_data_wr_addr),
    .datamem_wr_data(u2_datamem_wr_data), .store_to_mem(u2_store_to_mem), .dmem_dout(8'h00)
  );

  // Unwritten locations read back as addr_lo ^ addr_hi so wrong addresses show up
  assign dmem_dout = written[data_rd_addr] ? mem[data_rd_addr]
                                           : (data_rd_addr[7:0] ^ data_rd_addr[15:8]);

  always @(posedge clk) begin
    if (store_to_mem) begin
      mem[data_wr_addr]     <= datamem_wr_data;
      written[data_wr_addr] <= 1'b1;
      strobe_count          <= strobe_count + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic waitReady();
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) checkOutput("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic releaseReq();
    req_valid    = 1'b0;
    req_is_store = 1'bx;
    req_base     = 'x;
    req_offset   = 'x;
    req_wdata    = 'x;
    req_rd       = 'x;
  endtask

  // Present one request for a single cycle; returns at the negedge after acceptance
  task automatic applyStimulus(input logic st, input logic [15:0] base, input logic [7:0] off,
                               input logic [7:0] wdata, input logic [2:0] rd);
    waitReady();
    req_valid    = 1'b1;
    req_is_store = st;
    req_base     = base;
    req_offset   = off;
    req_wdata    = wdata;
    req_rd       = rd;
    @(negedge clk);
    releaseReq();
  endtask

  task automatic runOp(input string tag, input logic st, input logic [15:0] base,
                       input logic [7:0] off, input logic [7:0] wdata, input logic [2:0] rd,
                       input logic [15:0] exp_ea, input logic exp_wrap, input logic [7:0] exp_data);
    applyStimulus(st, base, off, wdata, rd);
    checkOutput({tag, "_wrap"}, 32'(addr_wrap), 32'(exp_wrap));
    checkOutput({tag, "_busy"}, 32'(req_ready), 32'd0);
    if (st) begin
      checkOutput({tag, "_strobe"}, 32'(store_to_mem), 32'd1);
      checkOutput({tag, "_wr_addr"}, 32'(data_wr_addr), 32'(exp_ea));
      checkOutput({tag, "_wr_data"}, 32'(datamem_wr_data), 32'(wdata));
      checkOutput({tag, "_rd_addr_kept"}, 32'(data_rd_addr), 32'(exp_rd_addr));
      @(negedge clk);
      checkOutput({tag, "_strobe_off"}, 32'(store_to_mem), 32'd0);
      checkOutput({tag, "_ready"}, 32'(req_ready), 32'd1);
    end else begin
      exp_rd_addr = exp_ea;
      checkOutput({tag, "_rd_addr"}, 32'(data_rd_addr), 32'(exp_ea));
      checkOutput({tag, "_wb_early"}, 32'(wb_valid), 32'd0);
      @(negedge clk);
      checkOutput({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
      checkOutput({tag, "_wb_data"}, 32'(wb_data), 32'(exp_data));
      checkOutput({tag, "_wb_rd"}, 32'(wb_rd), 32'(rd));
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      checkOutput({tag, "_wb_clear"}, 32'(wb_valid), 32'd0);
      checkOutput({tag, "_ready"}, 32'(req_ready), 32'd1);
    end
  endtask

  typedef struct {
    logic        st;
    logic [15:0] base;
    logic [7:0]  off;
    logic [7:0]  wdata;
    logic [2:0]  rd;
    logic [15:0] ea;
    logic        wrap;
    logic [7:0]  data;
  } op_t;

  op_t mix_ops [8];
  logic [15:0] u2_base [3];
  logic [7:0]  u2_off  [3];
  logic [15:0] u2_ea   [3];
  logic        u2_wrap [3];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    wb_ready = 1'b0;
    u2_req_valid = 1'b0;
    u2_req_base = '0;
    u2_req_offset = '0;
    exp_rd_addr = '0;
    releaseReq();

    repeat (3) @(negedge clk);
    checkOutput("rst_strobe", 32'(store_to_mem), 32'd0);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_rd_addr", 32'(data_rd_addr), 32'd0);
    checkOutput("rst_wrap", 32'(addr_wrap), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready), 32'd1);

    // Reset asserted while a store strobe is high
    applyStimulus(1'b1, 16'h2000, 8'h00, 8'h77, 3'd0);
    checkOutput("abort_strobe_before", 32'(store_to_mem), 32'd1);
    #2 reset = 1'b0;
    #1 checkOutput("abort_strobe_drop", 32'(store_to_mem), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_mem_untouched", 32'(written[16'h2000]), 32'd0);
    checkOutput("abort_ready", 32'(req_ready), 32'd1);
    checkOutput("abort_no_strobe", 32'(strobe_count), 32'd0);

    runOp("st_1239", 1'b1, 16'h1234, 8'h05, 8'hA5, 3'd0, 16'h1239, 1'b0, 8'h00);
    runOp("ld_1239", 1'b0, 16'h1234, 8'h05, 8'h00, 3'd3, 16'h1239, 1'b0, 8'hA5);
    checkOutput("one_strobe_first", 32'(strobe_count), 32'd1);

    runOp("ld_wrap_pos", 1'b0, 16'hFFFF, 8'h02, 8'h00, 3'd1, 16'h0001, 1'b1, 8'h01);
    runOp("ld_wrap_neg", 1'b0, 16'h0001, 8'hFE, 8'h00, 3'd2, 16'hFFFF, 1'b1, 8'h00);
    runOp("ld_neg_nowrap", 1'b0, 16'h1234, 8'hFE, 8'h00, 3'd7, 16'h1232, 1'b0, 8'h20);

    u2_base = '{16'h0010, 16'hFFF0, 16'h0001};
    u2_off  = '{8'hF0, 8'h20, 8'hFE};
    u2_ea   = '{16'h0100, 16'h0010, 16'h00FF};
    u2_wrap = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      u2_req_valid  = 1'b1;
      u2_req_base   = u2_base[i];
      u2_req_offset = u2_off[i];
      @(negedge clk);
      u2_req_valid = 1'b0;
      checkOutput($sformatf("unsigned_ea_%0d", i), 32'(u2_data_rd_addr), 32'(u2_ea[i]));
      checkOutput($sformatf("unsigned_wrap_%0d", i), 32'(u2_addr_wrap), 32'(u2_wrap[i]));
      repeat (3) @(negedge clk);
    end

    // Writeback stall with a competing store held on the request port
    applyStimulus(1'b0, 16'h1239, 8'h00, 8'h00, 3'd5);
    exp_rd_addr = 16'h1239;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_base = 16'h1239;
    req_offset = 8'h00; req_wdata = 8'h11; req_rd = 3'd0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("stall_valid_%0d", i), 32'(wb_valid), 32'd1);
      checkOutput($sformatf("stall_data_%0d", i), 32'(wb_data), 32'hA5);
      checkOutput($sformatf("stall_rd_%0d", i), 32'(wb_rd), 32'd5);
      checkOutput($sformatf("stall_busy_%0d", i), 32'(req_ready), 32'd0);
      checkOutput($sformatf("stall_no_strobe_%0d", i), 32'(store_to_mem), 32'd0);
      @(negedge clk);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    checkOutput("stall_consumed", 32'(wb_valid), 32'd0);
    checkOutput("stall_ready", 32'(req_ready), 32'd1);
    checkOutput("stall_store_wait", 32'(store_to_mem), 32'd0);
    @(negedge clk);
    releaseReq();
    checkOutput("held_store_strobe", 32'(store_to_mem), 32'd1);
    checkOutput("held_store_addr", 32'(data_wr_addr), 32'h1239);
    checkOutput("held_store_rd_kept", 32'(data_rd_addr), 32'h1239);
    @(negedge clk);
    checkOutput("held_store_done", 32'(store_to_mem), 32'd0);

    mix_ops = '{
      '{1'b1, 16'h4000, 8'h10, 8'h3C, 3'd0, 16'h4010, 1'b0, 8'h00},
      '{1'b1, 16'h4010, 8'hFF, 8'hC3, 3'd0, 16'h400F, 1'b0, 8'h00},
      '{1'b0, 16'h4000, 8'h10, 8'h00, 3'd1, 16'h4010, 1'b0, 8'h3C},
      '{1'b0, 16'h4010, 8'hFF, 8'h00, 3'd2, 16'h400F, 1'b0, 8'hC3},
      '{1'b1, 16'h4010, 8'h00, 8'h99, 3'd0, 16'h4010, 1'b0, 8'h00},
      '{1'b0, 16'h400F, 8'h01, 8'h00, 3'd4, 16'h4010, 1'b0, 8'h99},
      '{1'b0, 16'h1239, 8'h00, 8'h00, 3'd6, 16'h1239, 1'b0, 8'h11},
      '{1'b0, 16'h0100, 8'h80, 8'h00, 3'd3, 16'h0080, 1'b0, 8'h80}
    };
    for (int i = 0; i < 8; i++)
      runOp($sformatf("mix_%0d", i), mix_ops[i].st, mix_ops[i].base, mix_ops[i].off,
            mix_ops[i].wdata, mix_ops[i].rd, mix_ops[i].ea, mix_ops[i].wrap, mix_ops[i].data);
    checkOutput("strobe_total", 32'(strobe_count), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
